// File: rtl/pause_arbiter.sv
// rtl/pause_arbiter.sv - CPU-pause arbiter granting one requester at a time once the CPU is halted
//
// Purpose:
//   Requesters raise a level req to get exclusive access while the CPU is stopped.
//   The arbiter asks the CPU to halt (pause_cpu), waits for cpu_halted or a timeout,
//   then grants requesters one at a time in round-robin order. Back-to-back requesters
//   are handed off without releasing the CPU. When nobody is left, pause_cpu drops and
//   the block waits for the CPU to report it is running again before going idle.
//
// Ports:
//   clk_sys      in   core system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   [NREQ] per-requester pause request (level)
//   gnt          out  [NREQ] one-hot or zero grant, registered
//   pause_cpu    out  halt request to the CPU, registered
//   cpu_halted   in   CPU halt acknowledge, synchronous to clk_sys
//   busy         out  high whenever the FSM is not IDLE
//   timeout_err  out  sticky, set when a grant was forced by timeout

module pause_arbiter #(
    parameter int NREQ        = 4,
    parameter int ACK_TIMEOUT = 3000
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            pause_cpu,
    input  logic            cpu_halted,
    output logic            busy,
    output logic            timeout_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 20;

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        GRANTED,
        HANDOFF,
        RELEASE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [IDX_W-1:0] last_idx;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    logic             ack_seen;
    logic             tmo_hit;
    logic             gnt_held;
    logic             others_req;

    // Round-robin search: first requester at or after last_idx+1, wrapping.
    // last_idx resets to NREQ-1 so the very first search starts at index 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(last_idx) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign ack_seen = cpu_halted;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    // gnt is one-hot while GRANTED, so it doubles as the mask of the current owner.
    assign gnt_held   = |(req & gnt);
    assign others_req = |(req & ~gnt);

    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt         <= '0;
            pause_cpu   <= 1'b0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
            last_idx    <= LAST_INIT;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (|req) begin
                        state     <= HALT_WAIT;
                        pause_cpu <= 1'b1;
                    end
                end

                HALT_WAIT: begin
                    if (ack_seen || tmo_hit) begin
                        tmo_cnt <= '0;
                        // An acknowledge on the last counted cycle is still a clean handshake.
                        if (!ack_seen) begin
                            timeout_err <= 1'b1;
                        end
                        if (win_found) begin
                            state         <= GRANTED;
                            gnt           <= '0;
                            gnt[win_idx]  <= 1'b1;
                            last_idx      <= win_idx;
                        end else begin
                            // Everyone withdrew while we waited: back out without a grant.
                            state     <= RELEASE;
                            pause_cpu <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                GRANTED: begin
                    // New requests from other indices are deliberately ignored here;
                    // only the owner dropping its req ends the grant.
                    if (!gnt_held) begin
                        gnt <= '0;
                        if (others_req) begin
                            state <= HANDOFF;
                        end else begin
                            state     <= RELEASE;
                            pause_cpu <= 1'b0;
                        end
                    end
                end

                HANDOFF: begin
                    // One dead cycle with gnt low keeps the old and new owner from overlapping.
                    if (win_found) begin
                        state        <= GRANTED;
                        gnt          <= '0;
                        gnt[win_idx] <= 1'b1;
                        last_idx     <= win_idx;
                    end else begin
                        state     <= RELEASE;
                        pause_cpu <= 1'b0;
                    end
                end

                RELEASE: begin
                    // Requests are not looked at until the CPU confirms it is running.
                    if (!cpu_halted) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    pause_cpu <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pause_arbiter.sv
// tb/tb_pause_arbiter.sv - directed self-checking bench for pause_arbiter

module tb_pause_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 10;

    logic            clk_sys;
    logic            reset_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            pause_cpu;
    logic            cpu_halted;
    logic            busy;
    logic            timeout_err;

    int n_checks;
    int n_fail;

    pause_arbiter #(
        .NREQ        (NREQ),
        .ACK_TIMEOUT (TMO)
    ) u_dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .req         (req),
        .gnt         (gnt),
        .pause_cpu   (pause_cpu),
        .cpu_halted  (cpu_halted),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge; gnt must never be multi-hot.
    task automatic step();
        @(posedge clk_sys);
        #1;
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    logic [NREQ-1:0] rr_seq [5];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        req        = '0;
        cpu_halted = 1'b0;
        rr_seq[0]  = 4'b0001;
        rr_seq[1]  = 4'b0010;
        rr_seq[2]  = 4'b0100;
        rr_seq[3]  = 4'b1000;
        rr_seq[4]  = 4'b0001;

        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_pause", 32'(pause_cpu), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tmo", 32'(timeout_err), 32'h0);
        reset_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'h0);

        // Single requester, halt ack 5 cycles after pause; extra req during GRANTED; handoff.
        req = 4'b0001;
        step();
        check("t1_pause", 32'(pause_cpu), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t1_wait_gnt", 32'(gnt), 32'h0);
            check("t1_wait_busy", 32'(busy), 32'h1);
        end
        cpu_halted = 1'b1;
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy_g", 32'(busy), 32'h1);
        req = 4'b0101;
        step();
        check("t1_gnt_hold", 32'(gnt), 32'h1);
        req = 4'b0100;
        step();
        check("t1_handoff_gnt", 32'(gnt), 32'h0);
        check("t1_handoff_pause", 32'(pause_cpu), 32'h1);
        step();
        check("t1_gnt2", 32'(gnt), 32'h4);
        req = 4'b0000;
        step();
        check("t1_rel_pause", 32'(pause_cpu), 32'h0);
        check("t1_rel_busy", 32'(busy), 32'h1);
        cpu_halted = 1'b0;
        step();
        check("t1_idle", 32'(busy), 32'h0);
        check("t1_no_tmo", 32'(timeout_err), 32'h0);

        // req 0110: grant 1, drop it, one handoff cycle, grant 2.
        req        = 4'b0110;
        cpu_halted = 1'b1;
        step();
        check("t2_pause", 32'(pause_cpu), 32'h1);
        check("t2_gnt0", 32'(gnt), 32'h0);
        step();
        check("t2_gnt_a", 32'(gnt), 32'h2);
        req = 4'b0100;
        step();
        check("t2_handoff_gnt", 32'(gnt), 32'h0);
        check("t2_handoff_pause", 32'(pause_cpu), 32'h1);
        step();
        check("t2_gnt_b", 32'(gnt), 32'h4);
        req = 4'b0000;
        step();
        cpu_halted = 1'b0;
        step();
        check("t2_idle", 32'(busy), 32'h0);

        // Timeout with cpu_halted stuck low: grant on cycle 11 after pause rises.
        req = 4'b1000;
        step();
        check("t3_pause", 32'(pause_cpu), 32'h1);
        for (int i = 1; i <= TMO - 1; i++) begin
            step();
            check("t3_wait_gnt", 32'(gnt), 32'h0);
            check("t3_wait_tmo", 32'(timeout_err), 32'h0);
        end
        step();
        check("t3_gnt", 32'(gnt), 32'h8);
        check("t3_tmo", 32'(timeout_err), 32'h1);
        req = 4'b0000;
        step();
        check("t3_rel_pause", 32'(pause_cpu), 32'h0);
        check("t3_rel_tmo", 32'(timeout_err), 32'h1);
        step();
        check("t3_idle", 32'(busy), 32'h0);
        check("t3_tmo_sticky", 32'(timeout_err), 32'h1);

        // All four requesting: round-robin order 0,1,2,3,0 through handoffs.
        req        = 4'b1111;
        cpu_halted = 1'b1;
        step();
        step();
        check("t4_rr0", 32'(gnt), 32'(rr_seq[0]));
        for (int k = 1; k <= 4; k++) begin
            req = 4'b1111 & ~rr_seq[k-1];
            step();
            check("t4_handoff", 32'(gnt), 32'h0);
            req = 4'b1111;
            step();
            check("t4_rr", 32'(gnt), 32'(rr_seq[k]));
        end
        req = 4'b0000;
        step();
        cpu_halted = 1'b0;
        step();
        check("t4_idle", 32'(busy), 32'h0);

        // Async reset during GRANTED, then re-entry with req still high.
        req        = 4'b0010;
        cpu_halted = 1'b1;
        step();
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'h0);
        check("t5_async_pause", 32'(pause_cpu), 32'h0);
        check("t5_async_busy", 32'(busy), 32'h0);
        check("t5_async_tmo", 32'(timeout_err), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        check("t5_rehalt_pause", 32'(pause_cpu), 32'h1);
        check("t5_rehalt_busy", 32'(busy), 32'h1);
        step();
        check("t5_regnt", 32'(gnt), 32'h2);

        // Owner drops req while the CPU stays halted for 3 cycles.
        req = 4'b0000;
        step();
        check("t6_pause", 32'(pause_cpu), 32'h0);
        check("t6_gnt", 32'(gnt), 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t6_busy", 32'(busy), 32'h1);
        end
        cpu_halted = 1'b0;
        step();
        check("t6_idle", 32'(busy), 32'h0);

        // Requester withdraws during HALT_WAIT; new req during RELEASE is ignored.
        req = 4'b0001;
        step();
        req        = 4'b0000;
        cpu_halted = 1'b1;
        step();
        check("t7_no_gnt", 32'(gnt), 32'h0);
        check("t7_rel_pause", 32'(pause_cpu), 32'h0);
        check("t7_rel_busy", 32'(busy), 32'h1);
        req = 4'b0001;
        step();
        check("t7_ignore_pause", 32'(pause_cpu), 32'h0);
        check("t7_ignore_gnt", 32'(gnt), 32'h0);
        cpu_halted = 1'b0;
        step();
        check("t7_idle_pause", 32'(pause_cpu), 32'h0);
        step();
        check("t7_new_pause", 32'(pause_cpu), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pause_arbiter.md
PAUSE_ARBITER -- requirements
Module: pause_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of pause requesters (2..8).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 3000, meaning cycles to wait for CPU halt acknowledge before forcing a grant (1..2^20-1).
REQ-003 The block SHALL have port clk_sys  input  1  core system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  NREQ  per-requester pause request, level, held high until the requester is finished.
REQ-006 The block SHALL have port gnt  output  NREQ  one-hot (or zero) grant, registered.
REQ-007 The block SHALL have port pause_cpu  output  1  halt request to the CPU, registered.
REQ-008 The block SHALL have port cpu_halted  input  1  CPU acknowledges it is stopped, synchronous to clk_sys.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port timeout_err  output  1  sticky flag, set when a grant was forced by timeout.

Function
REQ-011 The FSM SHALL have states IDLE, HALT_WAIT, GRANTED, HANDOFF and RELEASE.
REQ-012 IDLE -> HALT_WAIT when any req bit is high; pause_cpu rises on the same clock edge.
REQ-013 In HALT_WAIT, pause_cpu SHALL stay high and a timeout counter SHALL increment by one per cycle from 0.
REQ-014 HALT_WAIT -> GRANTED on the first cycle cpu_halted=1, or when the counter reaches ACK_TIMEOUT-1; the timeout path also sets timeout_err.
REQ-015 Winner selection SHALL be round-robin: search starts at the index one above the last granted index (initially 0), wrapping modulo NREQ.
REQ-016 The winner SHALL be evaluated from req on the HALT_WAIT->GRANTED or HANDOFF->GRANTED transition cycle; gnt is asserted from the following cycle for that index only.
REQ-017 If all req bits are low when HALT_WAIT would exit, the FSM SHALL go to RELEASE with no grant issued.
REQ-018 In GRANTED, gnt SHALL hold until req[granted] falls; on that cycle gnt clears, and the FSM moves to HANDOFF if any other req bit is high, otherwise to RELEASE.
REQ-019 HANDOFF SHALL last exactly one cycle with gnt all-zero and pause_cpu held high, then return to GRANTED via round-robin selection.
REQ-020 In RELEASE, pause_cpu SHALL be low; RELEASE -> IDLE once cpu_halted=0; a new req arriving in RELEASE SHALL be ignored until IDLE.
REQ-021 gnt SHALL never have more than one bit set, and SHALL be non-zero only in GRANTED.
REQ-022 Raising req bits other than the granted one during GRANTED SHALL not change gnt.
REQ-023 Dropping the granted req during HALT_WAIT or HANDOFF SHALL be tolerated; selection uses req as sampled per REQ-016.
REQ-024 timeout_err SHALL clear only on reset.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force state IDLE, gnt=0, pause_cpu=0, busy=0, timeout_err=0, counter=0, last-granted index=NREQ-1.
REQ-026 Reset asserted mid-operation (any state) SHALL drop gnt and pause_cpu without passing through RELEASE.

Verification
REQ-027 req=0001, cpu_halted rises 5 cycles after pause_cpu -> gnt=0001 on the cycle after cpu_halted first samples high; busy=1 throughout.
REQ-028 req=0110 held, then req[1] dropped -> gnt=0010, one HANDOFF cycle with gnt=0000 and pause_cpu=1, then gnt=0100.
REQ-029 cpu_halted held 0, ACK_TIMEOUT=10, req=1000 -> gnt=1000 on cycle 11 after pause_cpu rises; timeout_err=1 and remains set after release.
REQ-030 All four req high for repeated grant/release cycles -> grant order 0,1,2,3,0; no cycle ever shows two gnt bits set.
REQ-031 reset_n pulsed low during GRANTED -> gnt=0 and pause_cpu=0 asynchronously; after reset_n=1 with req still high, the FSM re-enters HALT_WAIT on the next edge.
REQ-032 Granted requester drops req while cpu_halted stays high for 3 cycles -> pause_cpu=0 at once, busy=1 until cpu_halted=0, then IDLE.
